// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller feeding the CP0 register file.
package interrupt_ctrl_pkg;

    localparam int NUM_IRQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ENTER,
        ST_SERVICE
    } irq_state_t;

    // Lowest set index wins; returns 0 for an empty vector (caller guards with |vec).
    function automatic logic [2:0] lowest_pending(input logic [NUM_IRQ-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_ctrl_sync.sv
// Per-line synchronizer chain followed by a rising-edge detector on the synced level.
module irq_sync_edge
    import interrupt_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain   <= '0;
            level_d <= 1'b0;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], irq_async};
            level_d <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = chain[SYNC_STAGES-1] & ~level_d;

endmodule

// File: rtl/interrupt_ctrl.sv
// Single-level interrupt controller: synchronizes IRQ lines, tracks pending bits, handshakes
// with the pipeline and drives the CP0 EPC/CAUSE/STATUS write strobes.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [7:0]  IRQ_EDGE_MASK = 8'hFF,
    parameter logic [31:0] HANDLER_ADDR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_in,
    input  logic        status_ie,
    input  logic        int_ack,
    input  logic [31:0] epc_in,
    input  logic        eret,
    output logic        int_req,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        en_w_epc,
    output logic [31:0] data_w_epc,
    output logic [2:0]  interrupter_no,
    output logic        en_w_status_reset,
    output logic        en_w_status_set,
    output logic [7:0]  pending
);

    logic [7:0] sync_level;
    logic [7:0] sync_rise;
    logic [7:0] take_clr;
    irq_state_t state;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst      (rst),
            .irq_async(irq_in[i]),
            .level    (sync_level[i]),
            .rise     (sync_rise[i])
        );
    end

    always_comb begin
        take_clr = '0;
        if (state == ST_REQ && int_ack) take_clr[interrupter_no] = 1'b1;
    end

    // Edge lines: a new rising edge beats the clear of the line being taken in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (IRQ_EDGE_MASK & ((pending & ~take_clr) | sync_rise))
                     | (~IRQ_EDGE_MASK & sync_level);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            int_req           <= 1'b0;
            redirect          <= 1'b0;
            redirect_pc       <= '0;
            en_w_epc          <= 1'b0;
            data_w_epc        <= '0;
            interrupter_no    <= '0;
            en_w_status_reset <= 1'b0;
            en_w_status_set   <= 1'b0;
        end else begin
            en_w_epc          <= 1'b0;
            en_w_status_reset <= 1'b0;
            redirect          <= 1'b0;
            redirect_pc       <= '0;
            en_w_status_set   <= eret;
            case (state)
                ST_IDLE: begin
                    if (status_ie && (|pending) && !eret) begin
                        state          <= ST_REQ;
                        interrupter_no <= lowest_pending(pending);
                        int_req        <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state             <= ST_ENTER;
                        data_w_epc        <= epc_in;
                        int_req           <= 1'b0;
                        en_w_epc          <= 1'b1;
                        en_w_status_reset <= 1'b1;
                        redirect          <= 1'b1;
                        redirect_pc       <= HANDLER_ADDR;
                    end else if (!status_ie) begin
                        state   <= ST_IDLE;
                        int_req <= 1'b0;
                    end
                end
                ST_ENTER: begin
                    state <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (eret) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboard bench for interrupt_ctrl: directed scenarios plus randomized interrupt traffic,
// with a small CP0 STATUS model closing the status_ie loop.
module tb_interrupt_ctrl;

    localparam int          SYNC      = 2;
    localparam logic [7:0]  EDGE_MASK = 8'hFE;
    localparam logic [31:0] HANDLER   = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        status_ie;
    logic        int_ack;
    logic [31:0] epc_in;
    logic        eret;
    logic        int_req;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        en_w_epc;
    logic [31:0] data_w_epc;
    logic [2:0]  interrupter_no;
    logic        en_w_status_reset;
    logic        en_w_status_set;
    logic [7:0]  pending;

    typedef struct packed {
        logic [2:0]  no;
        logic [31:0] epc;
        logic        pend_after;
    } entry_t;

    entry_t     exp_entry[$];
    int         exp_set[$];
    entry_t     mon_e;
    logic [7:0] model_pend = 8'h00;
    logic       level_hi = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    interrupt_ctrl #(
        .SYNC_STAGES  (SYNC),
        .IRQ_EDGE_MASK(EDGE_MASK),
        .HANDLER_ADDR (HANDLER)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .irq_in           (irq_in),
        .status_ie        (status_ie),
        .int_ack          (int_ack),
        .epc_in           (epc_in),
        .eret             (eret),
        .int_req          (int_req),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .en_w_epc         (en_w_epc),
        .data_w_epc       (data_w_epc),
        .interrupter_no   (interrupter_no),
        .en_w_status_reset(en_w_status_reset),
        .en_w_status_set  (en_w_status_set),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got a pulse, expected none", name);
    endtask

    // CP0 STATUS register stand-in: the controller's strobes write it, software may override it.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_w_status_reset) status_ie = 1'b0;
            else if (en_w_status_set) status_ie = 1'b1;
        end
    end

    // Monitor: every write strobe the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_w_epc) begin
                if (exp_entry.size() == 0) begin
                    reportUnexpected("entry_en_w_epc");
                end else begin
                    mon_e = exp_entry.pop_front();
                    checkOutput("interrupter_no", {29'd0, interrupter_no}, {29'd0, mon_e.no});
                    checkOutput("data_w_epc", data_w_epc, mon_e.epc);
                    checkOutput("redirect_pc", redirect_pc, HANDLER);
                    checkOutput("redirect", {31'd0, redirect}, 32'd1);
                    checkOutput("en_w_status_reset", {31'd0, en_w_status_reset}, 32'd1);
                    checkOutput("int_req_at_entry", {31'd0, int_req}, 32'd0);
                    checkOutput("pending_taken_bit", {31'd0, pending[mon_e.no]}, {31'd0, mon_e.pend_after});
                end
            end
            if (en_w_status_set) begin
                if (exp_set.size() == 0) begin
                    reportUnexpected("en_w_status_set");
                end else begin
                    void'(exp_set.pop_front());
                    vectors++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] mask);
        irq_in = irq_in | mask;
        tick(3);
        irq_in = irq_in & ~mask;
        model_pend = model_pend | (mask & EDGE_MASK);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!int_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, int_req}, 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_int_req"}, {31'd0, int_req}, 32'd0);
        checkOutput({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
        checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        checkOutput({tag, "_en_w_epc"}, {31'd0, en_w_epc}, 32'd0);
        checkOutput({tag, "_data_w_epc"}, data_w_epc, 32'd0);
        checkOutput({tag, "_interrupter_no"}, {29'd0, interrupter_no}, 32'd0);
        checkOutput({tag, "_status_reset"}, {31'd0, en_w_status_reset}, 32'd0);
        checkOutput({tag, "_status_set"}, {31'd0, en_w_status_set}, 32'd0);
        checkOutput({tag, "_pending"}, {24'd0, pending}, 32'd0);
    endtask

    // Reference choice: lowest pending index, found by isolating the least significant set bit.
    task automatic ackWinner(input logic [31:0] epc, input bit drop_status);
        logic [7:0] cand;
        logic [7:0] iso;
        entry_t     e;
        int         win = 0;
        cand = model_pend | {7'd0, level_hi};
        iso  = cand & (~cand + 8'd1);
        for (int i = 0; i < 8; i++) begin
            if (iso == (8'd1 << i)) win = i;
        end
        e.no         = 3'(win);
        e.epc        = epc;
        e.pend_after = EDGE_MASK[win] ? 1'b0 : level_hi;
        if (EDGE_MASK[win]) model_pend[win] = 1'b0;
        exp_entry.push_back(e);
        int_ack = 1'b1;
        epc_in  = epc;
        if (drop_status) status_ie = 1'b0;
        tick(1);
        int_ack = 1'b0;
        epc_in  = $urandom;
    endtask

    task automatic takeOne(input logic [31:0] epc, input bit drop_status, input bit withdraw,
                           input logic [7:0] extra, input bit release_level);
        waitReq("int_req_rise");
        @(posedge clk);
        #1;
        if (withdraw) begin
            status_ie = 1'b0;
            tick(1);
            @(negedge clk);
            checkOutput("withdraw_int_req", {31'd0, int_req}, 32'd0);
            checkOutput("withdraw_pending", {24'd0, pending}, {24'd0, model_pend | {7'd0, level_hi}});
            @(posedge clk);
            #1;
            status_ie = 1'b1;
            waitReq("rerequest_after_withdraw");
            @(posedge clk);
            #1;
        end
        tick($urandom_range(0, 2));
        ackWinner(epc, drop_status);
        tick(2);
        if (release_level) begin
            irq_in[0] = 1'b0;
            level_hi  = 1'b0;
        end
        if (extra != 8'h00) applyStimulus(extra);
        tick(SYNC + 3);
        checkOutput("pending_in_service", {24'd0, pending}, {24'd0, model_pend | {7'd0, level_hi}});
        checkOutput("no_req_in_service", {31'd0, int_req}, 32'd0);
        eret = 1'b1;
        exp_set.push_back(1);
        tick(1);
        eret = 1'b0;
    endtask

    initial begin
        logic [7:0] extra;
        rst       = 1'b1;
        irq_in    = 8'h00;
        status_ie = 1'b0;
        int_ack   = 1'b0;
        epc_in    = 32'h0;
        eret      = 1'b0;
        tick(3);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        $display("[TB] single edge interrupt on line 3");
        status_ie = 1'b1;
        applyStimulus(8'h08);
        takeOne(32'h0000_0040, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] simultaneous lines 2 and 5");
        applyStimulus(8'b0010_0100);
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] pending accumulates while interrupts are disabled");
        tick(4);
        status_ie = 1'b0;
        applyStimulus(8'h02);
        tick(6);
        checkOutput("masked_pending", {24'd0, pending}, {24'd0, model_pend});
        checkOutput("masked_no_req", {31'd0, int_req}, 32'd0);
        status_ie = 1'b1;
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] withdraw then ack racing a status drop");
        applyStimulus(8'h10);
        takeOne($urandom, 1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus(8'h40);
        takeOne($urandom, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("[TB] edge during service is held until after eret");
        applyStimulus(8'h80);
        takeOne($urandom, 1'b0, 1'b0, 8'h02, 1'b0);
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("[TB] spurious eret while idle");
        tick(4);
        eret = 1'b1;
        exp_set.push_back(1);
        tick(1);
        eret = 1'b0;
        tick(4);
        checkOutput("spurious_eret_no_req", {31'd0, int_req}, 32'd0);

        $display("[TB] level line 0 held across eret");
        irq_in[0] = 1'b1;
        level_hi  = 1'b1;
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("level_wait_status", {31'd0, int_req}, 32'd0);
        tick(1);
        checkOutput("level_rerequest", {31'd0, int_req}, 32'd1);
        takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(6);
        checkOutput("level_released_no_req", {31'd0, int_req}, 32'd0);
        checkOutput("level_released_pending", {24'd0, pending}, 32'd0);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 20; r++) begin
            if (model_pend == 8'h00) applyStimulus(8'($urandom_range(1, 127)) << 1);
            extra = ($urandom_range(0, 1) == 1) ? (8'($urandom) & EDGE_MASK) : 8'h00;
            takeOne($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), extra, 1'b0);
        end
        for (int g = 0; g < 10 && model_pend != 8'h00; g++) begin
            takeOne($urandom, 1'b0, 1'b0, 8'h00, 1'b0);
        end

        $display("[TB] reset while a request is outstanding");
        tick(4);
        applyStimulus(8'h20);
        waitReq("req_before_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        checkAllZero("reset_in_req");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_pend = 8'h00;
        tick(8);
        checkOutput("after_reset_no_req", {31'd0, int_req}, 32'd0);
        checkOutput("after_reset_pending", {24'd0, pending}, 32'd0);

        checkOutput("entry_queue_drained", exp_entry.size(), 32'd0);
        checkOutput("eret_queue_drained", exp_set.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
